mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Arbitrating memory controller between instruction fetch and the load/store unit, in front of the single byte-wide synchronous RAM port. It latches one-cycle request pulses from both clients and grants them round-robin. It serialises each access into 1/2/4 byte-wide RAM cycles and returns assembled little-endian data with a one-cycle done pulse.

## Interface
- No parameters.
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- instEn  in  1  fetch request pulse (one cycle)
- instAddr  in  32  fetch byte address
- instOutEn  out  1  fetch done pulse
- instData  out  32  fetched word, valid while instOutEn=1
- dataEn  in  1  LS request pulse (one cycle)
- LSRW  in  1  0=read, 1=write
- dataAddr  in  32  LS byte address
- LSlen  in  3  byte count minus one: 000=byte, 001=half, 011=word; bit 2 ignored
- Sdata  in  32  store data, byte i = Sdata[8i+7:8i]
- LSoutEn  out  1  LS done pulse (reads and writes)
- Ldata  out  32  load data, zero-extended raw bytes, valid while LSoutEn=1
- ramAddr  out  32  RAM byte address
- ramRW  out  1  0=read, 1=write
- ramWdata  out  8  RAM write byte
- ramRdata  in  8  RAM read byte; RAM registers ramAddr at edge k, data valid for capture at edge k+1

## Operation
- Pending latches: instPend and lsPend, set on the request pulse, holding the address, and LSRW/LSlen/Sdata for LS. A client must not re-request until its done pulse. A repeat request while that client is pending or in service is dropped.
- Grant rule, evaluated at every edge in IDLE over latched and same-edge requests:
  - Only one source requesting: grant it.
  - Both requesting: grant the source not served last.
  - lastServed resets to IF, so LS wins the first tie.
- Byte count n: IF n=4; LS n=LSlen[1:0]+1. Byte i uses address addr+i, with 32-bit wrap-around.
- States:
  - IDLE: ramAddr=0, ramRW=0, ramWdata=0.
  - READ: issue counter i=0..n-1, capture counter j. Captured byte j goes into data[8j+7:8j]. Unwritten upper bytes stay 0.
  - WRITE: issue counter i=0..n-1. ramRW=1, ramWdata=Sdata byte i.
- READ ends when byte n-1 is captured: the done pulse fires for the granted source, then the state returns to IDLE.
- WRITE ends the edge after the last byte is issued: LSoutEn pulses, Ldata=0, ramRW returns to 0, then the state returns to IDLE.
- instOutEn and LSoutEn are each high for exactly one cycle and are never both high.
- Done data persists until the next done pulse of the same port.
- Pending entries are cleared at grant. lastServed is updated at grant.

## Timing
- All outputs are registered.
- Reset values: instOutEn=0, instData=0, LSoutEn=0, Ldata=0, ramAddr=0, ramRW=0, ramWdata=0. Both pending latches clear; state=IDLE; lastServed=IF.
- Grant edge G0: ramAddr<=addr, byte 0 issued. Byte i is issued at G0+i.
- Read byte i is captured at G0+i+2. The done pulse is registered at G0+n+1, so a word read completes 5 cycles after grant.
- If the request pulse itself is granted on its sampling edge, grant latency is 0.
- Write byte i is driven at G0+i. LSoutEn is registered at G0+n; a word write takes 4 cycles.
- After done, the next grant occurs no earlier than the edge following the done edge.
- A request arriving while the controller is busy serving the other client is latched and granted at the first IDLE edge.
- Reset mid-transaction: immediate return to reset values. No done pulse is issued; pending requests are lost; a partial write is not completed.

## Test plan
- IF only: instEn pulse with instAddr=0x100, RAM[0x100..0x103]=11,22,33,44 -> ramAddr sequence 0x100..0x103, then 5 cycles after grant instOutEn=1, instData=0x44332211.
- LS write: SW of Sdata=0xDEADBEEF to 0x2000 -> ramRW=1 for 4 cycles with bytes EF,BE,AD,DE at 0x2000..0x2003, then LSoutEn pulse with Ldata=0. A following LB at 0x2002 returns Ldata=0x000000AD.
- Simultaneous: instEn and dataEn (LH at 0x10, RAM=0x80,0xFF) on the same edge after reset -> LS served first with Ldata=0x0000FF80, then IF. Repeating both again -> IF served first.
- Busy latch: during an IF word read, a dataEn pulse arrives -> LS is granted on the first IDLE edge after instOutEn, with no lost request and no overlapping RAM cycles.
- Wrap: LW at 0xFFFFFFFE -> ramAddr sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- Reset during the third byte of SW -> all outputs return to 0 immediately, no LSoutEn pulse, and a request after reset is served normally.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// Client request/done signals and the byte-wide RAM port of mem_ctrl.
// The slave modport is the controller's view; the master modport drives clients and RAM.
interface mem_ctrl_if;
  logic        instEn;
  logic [31:0] instAddr;
  logic        instOutEn;
  logic [31:0] instData;
  logic        dataEn;
  logic        LSRW;
  logic [31:0] dataAddr;
  logic [2:0]  LSlen;
  logic [31:0] Sdata;
  logic        LSoutEn;
  logic [31:0] Ldata;
  logic [31:0] ramAddr;
  logic        ramRW;
  logic [7:0]  ramWdata;
  logic [7:0]  ramRdata;

  modport slave (
    input  instEn, instAddr, dataEn, LSRW, dataAddr, LSlen, Sdata, ramRdata,
    output instOutEn, instData, LSoutEn, Ldata, ramAddr, ramRW, ramWdata
  );

  modport master (
    output instEn, instAddr, dataEn, LSRW, dataAddr, LSlen, Sdata, ramRdata,
    input  instOutEn, instData, LSoutEn, Ldata, ramAddr, ramRW, ramWdata
  );
endinterface

// File: rtl/mem_ctrl.sv
// Round-robin memory controller: latches fetch and load/store requests and serialises each
// access into byte-wide RAM cycles, returning little-endian data with a one-cycle done pulse.
module mem_ctrl (
  input logic        clk,
  input logic        rst,
  mem_ctrl_if.slave  bus_io
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

  state_e      state_q;
  logic        inst_pend_q, ls_pend_q;
  logic [31:0] inst_addr_q, ls_addr_q, ls_wdata_q;
  logic        ls_rw_q;
  logic [1:0]  ls_len_q;
  logic        src_ls_q, last_ls_q;
  logic [31:0] addr_q, wdata_q, data_q;
  logic [2:0]  n_q, cnt_q;

  logic        inst_out_en_q, ls_out_en_q;
  logic [31:0] inst_data_q, ldata_q;
  logic [31:0] ram_addr_q;
  logic        ram_rw_q;
  logic [7:0]  ram_wdata_q;

  logic        idle, inst_busy, ls_busy, inst_accept, ls_accept;
  logic        req_if, req_ls, grant_if, grant_ls;
  logic [31:0] g_inst_addr, g_ls_addr, g_ls_wdata, g_addr;
  logic        g_ls_rw, g_write;
  logic [1:0]  g_ls_len, cap_idx;
  logic [2:0]  g_n;
  logic [31:0] cap_word;
  logic        unused_len;

  assign unused_len = bus_io.LSlen[2];

  assign idle        = (state_q == StIdle);
  assign inst_busy   = !idle && !src_ls_q;
  assign ls_busy     = !idle && src_ls_q;
  // A repeat request while pending or in service is dropped.
  assign inst_accept = bus_io.instEn && !inst_pend_q && !inst_busy;
  assign ls_accept   = bus_io.dataEn && !ls_pend_q && !ls_busy;
  assign req_if      = inst_pend_q || inst_accept;
  assign req_ls      = ls_pend_q || ls_accept;
  assign grant_ls    = idle && req_ls && (!req_if || !last_ls_q);
  assign grant_if    = idle && req_if && !grant_ls;

  assign g_inst_addr = inst_pend_q ? inst_addr_q : bus_io.instAddr;
  assign g_ls_addr   = ls_pend_q ? ls_addr_q : bus_io.dataAddr;
  assign g_ls_wdata  = ls_pend_q ? ls_wdata_q : bus_io.Sdata;
  assign g_ls_rw     = ls_pend_q ? ls_rw_q : bus_io.LSRW;
  assign g_ls_len    = ls_pend_q ? ls_len_q : bus_io.LSlen[1:0];
  assign g_addr      = grant_ls ? g_ls_addr : g_inst_addr;
  assign g_write     = grant_ls && g_ls_rw;
  assign g_n         = grant_ls ? ({1'b0, g_ls_len} + 3'd1) : 3'd4;

  // Byte captured at counter value c was issued at c-2.
  assign cap_idx = 2'(cnt_q - 3'd2);

  always_comb begin
    cap_word = data_q;
    cap_word[{cap_idx, 3'b000} +: 8] = bus_io.ramRdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      inst_pend_q   <= 1'b0;
      ls_pend_q     <= 1'b0;
      inst_addr_q   <= '0;
      ls_addr_q     <= '0;
      ls_wdata_q    <= '0;
      ls_rw_q       <= 1'b0;
      ls_len_q      <= '0;
      src_ls_q      <= 1'b0;
      last_ls_q     <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      data_q        <= '0;
      n_q           <= '0;
      cnt_q         <= '0;
      inst_out_en_q <= 1'b0;
      inst_data_q   <= '0;
      ls_out_en_q   <= 1'b0;
      ldata_q       <= '0;
      ram_addr_q    <= '0;
      ram_rw_q      <= 1'b0;
      ram_wdata_q   <= '0;
    end else begin
      inst_out_en_q <= 1'b0;
      ls_out_en_q   <= 1'b0;

      if (grant_if) begin
        inst_pend_q <= 1'b0;
      end else if (inst_accept) begin
        inst_pend_q <= 1'b1;
        inst_addr_q <= bus_io.instAddr;
      end

      if (grant_ls) begin
        ls_pend_q <= 1'b0;
      end else if (ls_accept) begin
        ls_pend_q  <= 1'b1;
        ls_addr_q  <= bus_io.dataAddr;
        ls_wdata_q <= bus_io.Sdata;
        ls_rw_q    <= bus_io.LSRW;
        ls_len_q   <= bus_io.LSlen[1:0];
      end

      unique case (state_q)
        StIdle: begin
          if (grant_if || grant_ls) begin
            src_ls_q    <= grant_ls;
            last_ls_q   <= grant_ls;
            addr_q      <= g_addr;
            wdata_q     <= g_ls_wdata;
            n_q         <= g_n;
            data_q      <= '0;
            cnt_q       <= 3'd1;
            ram_addr_q  <= g_addr;
            ram_rw_q    <= g_write;
            ram_wdata_q <= g_write ? g_ls_wdata[7:0] : 8'h00;
            state_q     <= g_write ? StWrite : StRead;
          end
        end
        StRead: begin
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q < n_q) begin
            ram_addr_q <= addr_q + 32'(cnt_q);
          end
          if (cnt_q >= 3'd2) begin
            data_q <= cap_word;
          end
          if (cnt_q == n_q + 3'd1) begin
            if (src_ls_q) begin
              ls_out_en_q <= 1'b1;
              ldata_q     <= cap_word;
            end else begin
              inst_out_en_q <= 1'b1;
              inst_data_q   <= cap_word;
            end
            ram_addr_q <= '0;
            state_q    <= StIdle;
          end
        end
        StWrite: begin
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q < n_q) begin
            ram_addr_q  <= addr_q + 32'(cnt_q);
            ram_wdata_q <= wdata_q[{cnt_q[1:0], 3'b000} +: 8];
          end else begin
            ls_out_en_q <= 1'b1;
            ldata_q     <= '0;
            ram_addr_q  <= '0;
            ram_rw_q    <= 1'b0;
            ram_wdata_q <= '0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.instOutEn = inst_out_en_q;
  assign bus_io.instData  = inst_data_q;
  assign bus_io.LSoutEn   = ls_out_en_q;
  assign bus_io.Ldata     = ldata_q;
  assign bus_io.ramAddr   = ram_addr_q;
  assign bus_io.ramRW     = ram_rw_q;
  assign bus_io.ramWdata  = ram_wdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM model, reference memory and round-robin model,
// directed scenarios followed by randomized single and simultaneous requests.
module tb_mem_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_ctrl_if bus ();
  mem_ctrl dut (.clk(clk), .rst(rst), .bus_io(bus.slave));

  bit [7:0] mem [65536];
  bit [7:0] ref_mem [65536];
  logic        bd_we = 1'b0;
  logic [15:0] bd_addr = '0;
  logic [7:0]  bd_data = '0;

  // RAM registers the address at one edge; the data is captured at the next.
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (bus.ramRW) mem[bus.ramAddr[15:0]] <= bus.ramWdata;
    bus.ramRdata <= mem[bus.ramAddr[15:0]];
  end

  int pass_cnt = 0;
  int chk_cnt = 0;
  bit last_ls = 1'b0;

  function automatic logic [31:0] exp_read(input logic [31:0] addr, input int n);
    logic [31:0] w = '0;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = addr + 32'(i);
      w[8*i +: 8] = ref_mem[a[15:0]];
    end
    return w;
  endfunction

  task automatic poke(input logic [31:0] addr, input logic [7:0] data);
    bd_addr = addr[15:0];
    bd_data = data;
    bd_we = 1'b1;
    @(posedge clk); #1;
    bd_we = 1'b0;
    ref_mem[addr[15:0]] = data;
  endtask

  // Called 1 time unit after an edge; returns 1 time unit after the sampling edge.
  task automatic start(input bit en_if, input bit en_ls, input logic [31:0] a_if,
                       input bit rw, input logic [31:0] a_ls, input logic [2:0] len,
                       input logic [31:0] sd);
    bus.instAddr = a_if;
    bus.LSRW = rw;
    bus.dataAddr = a_ls;
    bus.LSlen = len;
    bus.Sdata = sd;
    bus.instEn = en_if;
    bus.dataEn = en_ls;
    @(posedge clk); #1;
    bus.instEn = 1'b0;
    bus.dataEn = 1'b0;
  endtask

  task automatic expect_read(input bit is_ls, input logic [31:0] addr, input int n,
                             input logic [31:0] exp, input int inject);
    for (int k = 0; k <= n + 1; k++) begin
      if (k < n) begin
        chk_cnt++;
        if ({bus.ramAddr, bus.ramRW} !== {addr + 32'(k), 1'b0})
          $display("FAIL rd_issue k=%0d: got addr=%h rw=%b, want addr=%h rw=0",
                   k, bus.ramAddr, bus.ramRW, addr + 32'(k));
        else pass_cnt++;
      end
      chk_cnt++;
      if (k <= n) begin
        if ({bus.instOutEn, bus.LSoutEn} !== 2'b00)
          $display("FAIL rd_early k=%0d: got inst/ls done=%b%b, want 00",
                   k, bus.instOutEn, bus.LSoutEn);
        else pass_cnt++;
      end else if (is_ls) begin
        if ({bus.instOutEn, bus.LSoutEn, bus.Ldata} !== {2'b01, exp})
          $display("FAIL ls_done: got en=%b%b Ldata=%h, want en=01 Ldata=%h",
                   bus.instOutEn, bus.LSoutEn, bus.Ldata, exp);
        else pass_cnt++;
      end else begin
        if ({bus.instOutEn, bus.LSoutEn, bus.instData} !== {2'b10, exp})
          $display("FAIL if_done: got en=%b%b instData=%h, want en=10 instData=%h",
                   bus.instOutEn, bus.LSoutEn, bus.instData, exp);
        else pass_cnt++;
      end
      bus.dataEn = (k == inject);
      if (k <= n) begin
        @(posedge clk); #1;
      end
    end
    bus.dataEn = 1'b0;
  endtask

  task automatic expect_write(input logic [31:0] addr, input int n, input logic [31:0] sd);
    logic [31:0] a;
    for (int k = 0; k <= n; k++) begin
      chk_cnt++;
      if (k < n) begin
        a = addr + 32'(k);
        if ({bus.ramAddr, bus.ramRW, bus.ramWdata, bus.instOutEn, bus.LSoutEn} !==
            {a, 1'b1, sd[8*k +: 8], 2'b00})
          $display("FAIL wr_issue k=%0d: got addr=%h rw=%b wd=%h en=%b%b, want %h 1 %h 00",
                   k, bus.ramAddr, bus.ramRW, bus.ramWdata, bus.instOutEn, bus.LSoutEn,
                   a, sd[8*k +: 8]);
        else pass_cnt++;
        ref_mem[a[15:0]] = sd[8*k +: 8];
        @(posedge clk); #1;
      end else begin
        if ({bus.instOutEn, bus.LSoutEn, bus.Ldata, bus.ramRW} !== {2'b01, 32'h0, 1'b0})
          $display("FAIL wr_done: got en=%b%b Ldata=%h rw=%b, want en=01 Ldata=0 rw=0",
                   bus.instOutEn, bus.LSoutEn, bus.Ldata, bus.ramRW);
        else pass_cnt++;
      end
    end
  endtask

  // Expected behaviour of one granted access; entered just after its grant edge.
  task automatic serve(input bit is_ls, input bit rw, input logic [31:0] addr,
                       input logic [2:0] len, input logic [31:0] sd, input int inject);
    int n;
    n = is_ls ? int'(len[1:0]) + 1 : 4;
    if (is_ls && rw) expect_write(addr, n, sd);
    else expect_read(is_ls, addr, n, exp_read(addr, n), inject);
    last_ls = is_ls;
  endtask

  task automatic check_zero_outputs(input string name);
    chk_cnt++;
    if ({bus.instOutEn, bus.instData, bus.LSoutEn, bus.Ldata, bus.ramAddr, bus.ramRW,
         bus.ramWdata} !== '0)
      $display("FAIL %s: got en=%b%b inst=%h ld=%h ra=%h rw=%b wd=%h, want all 0", name,
               bus.instOutEn, bus.LSoutEn, bus.instData, bus.Ldata, bus.ramAddr, bus.ramRW,
               bus.ramWdata);
    else pass_cnt++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_zero_outputs("reset_outputs");
    @(posedge clk); #1;
    rst = 1'b0;
    last_ls = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset_state");
    rst = 1'b0;
  endtask

  task automatic test_if_only();
    poke(32'h100, 8'h11);
    poke(32'h101, 8'h22);
    poke(32'h102, 8'h33);
    poke(32'h103, 8'h44);
    start(1, 0, 32'h100, 0, 0, 0, 0);
    serve(0, 0, 32'h100, 0, 0, -1);
    chk_cnt++;
    if (bus.instData !== 32'h44332211)
      $display("FAIL if_word: got %h, want 44332211", bus.instData);
    else pass_cnt++;
  endtask

  task automatic test_ls_write();
    start(0, 1, 0, 1, 32'h2000, 3'b011, 32'hDEADBEEF);
    serve(1, 1, 32'h2000, 3'b011, 32'hDEADBEEF, -1);
    start(0, 1, 0, 0, 32'h2002, 3'b000, 0);
    serve(1, 0, 32'h2002, 3'b000, 0, -1);
    chk_cnt++;
    if (bus.Ldata !== 32'h000000AD)
      $display("FAIL lb_after_sw: got %h, want 000000AD", bus.Ldata);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    poke(32'h10, 8'h80);
    poke(32'h11, 8'hFF);
    for (int r = 0; r < 2; r++) begin
      start(1, 1, 32'h100, 0, 32'h10, 3'b001, 0);
      if (!last_ls) begin
        serve(1, 0, 32'h10, 3'b001, 0, -1);
        chk_cnt++;
        if (bus.Ldata !== 32'h0000FF80)
          $display("FAIL lh_first: got %h, want 0000FF80", bus.Ldata);
        else pass_cnt++;
        @(posedge clk); #1;
        serve(0, 0, 32'h100, 0, 0, -1);
      end else begin
        serve(0, 0, 32'h100, 0, 0, -1);
        @(posedge clk); #1;
        serve(1, 0, 32'h10, 3'b001, 0, -1);
      end
    end
  endtask

  task automatic test_busy_latch();
    bus.LSRW = 1'b0;
    bus.dataAddr = 32'h2000;
    bus.LSlen = 3'b011;
    start(1, 0, 32'h100, 0, 32'h2000, 3'b011, 0);
    serve(0, 0, 32'h100, 0, 0, 2);
    @(posedge clk); #1;
    serve(1, 0, 32'h2000, 3'b011, 0, -1);
    chk_cnt++;
    if ({bus.Ldata, bus.instData} !== {32'hDEADBEEF, 32'h44332211})
      $display("FAIL busy_latch: got Ldata=%h instData=%h, want DEADBEEF 44332211",
               bus.Ldata, bus.instData);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    poke(32'hFFFFFFFE, 8'hA0);
    poke(32'hFFFFFFFF, 8'hB1);
    poke(32'h00000000, 8'hC2);
    poke(32'h00000001, 8'hD3);
    start(0, 1, 0, 0, 32'hFFFFFFFE, 3'b011, 0);
    serve(1, 0, 32'hFFFFFFFE, 3'b011, 0, -1);
    chk_cnt++;
    if (bus.Ldata !== 32'hD3C2B1A0)
      $display("FAIL wrap_word: got %h, want D3C2B1A0", bus.Ldata);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_write();
    for (int i = 0; i < 4; i++) poke(32'h3000 + 32'(i), 8'hA1 + 8'(i));
    start(0, 1, 0, 1, 32'h3000, 3'b011, 32'h55667788);
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk_cnt++;
    if ({bus.ramAddr, bus.ramRW, bus.ramWdata} !== {32'h3002, 1'b1, 8'h66})
      $display("FAIL mid_write_byte2: got %h %b %h, want 00003002 1 66",
               bus.ramAddr, bus.ramRW, bus.ramWdata);
    else pass_cnt++;
    ref_mem[16'h3000] = 8'h88;
    ref_mem[16'h3001] = 8'h77;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      chk_cnt++;
      if ({bus.LSoutEn, bus.ramRW} !== 2'b00)
        $display("FAIL post_reset_idle k=%0d: got en=%b rw=%b, want 0 0",
                 k, bus.LSoutEn, bus.ramRW);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    start(0, 1, 0, 0, 32'h3000, 3'b011, 0);
    serve(1, 0, 32'h3000, 3'b011, 0, -1);
    chk_cnt++;
    if (bus.Ldata !== 32'hA4A37788)
      $display("FAIL partial_write: got %h, want A4A37788", bus.Ldata);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [31:0] a_if, a_ls, sd;
    logic [2:0]  len;
    bit          rw;
    int          mode;
    for (int i = 0; i < 72; i++) poke(32'h3100 + 32'(i), 8'($urandom));
    for (int r = 0; r < 40; r++) begin
      mode = int'($urandom_range(0, 2));
      a_if = 32'h3100 + 32'($urandom_range(0, 64));
      a_ls = 32'h3100 + 32'($urandom_range(0, 64));
      sd = $urandom;
      rw = 1'($urandom);
      len = {1'($urandom), 2'($urandom_range(0, 2))};
      if (len[1:0] == 2'b10) len[1:0] = 2'b11;
      start(mode != 1, mode != 0, a_if, rw, a_ls, len, sd);
      if (mode == 0) begin
        serve(0, 0, a_if, 0, 0, -1);
      end else if (mode == 1) begin
        serve(1, rw, a_ls, len, sd, -1);
      end else if (last_ls) begin
        serve(0, 0, a_if, 0, 0, -1);
        @(posedge clk); #1;
        serve(1, rw, a_ls, len, sd, -1);
      end else begin
        serve(1, rw, a_ls, len, sd, -1);
        @(posedge clk); #1;
        serve(0, 0, a_if, 0, 0, -1);
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    bus.instEn = 1'b0;
    bus.instAddr = '0;
    bus.dataEn = 1'b0;
    bus.LSRW = 1'b0;
    bus.dataAddr = '0;
    bus.LSlen = '0;
    bus.Sdata = '0;
    test_reset();
    test_if_only();
    test_ls_write();
    test_simultaneous();
    test_busy_latch();
    test_wrap();
    test_reset_mid_write();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
